apb_master: RTL and testbench

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_master.sv | 162 ++++++++++++++++
 tb/tb_apb_master.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
// APB master: turns a single-outstanding local command into an APB
// SETUP/ACCESS transfer and returns a one-cycle completion pulse.
// Optional feature: define APB_MASTER_TIMEOUT_EN to abort ACCESS after
// TIMEOUT_CYCLES wait states with an error response.
module apb_master #(
  parameter int ADDR_W         = 10,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic              cmd_write_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              psel_o,
  output logic              penable_o,
  output logic              pwrite_o,
  output logic [ADDR_W-1:0] paddr_o,
  output logic [DATA_W-1:0] pwdata_o,
  input  logic [DATA_W-1:0] prdata_i,
  input  logic              pready_i
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

  state_t              r_state, w_state_nxt;
  logic                r_psel, w_psel_nxt;
  logic                r_penable, w_penable_nxt;
  logic                r_pwrite, w_pwrite_nxt;
  logic [ADDR_W-1:0]   r_paddr, w_paddr_nxt;
  logic [DATA_W-1:0]   r_pwdata, w_pwdata_nxt;
  logic                r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_W-1:0]   r_rsp_rdata, w_rsp_rdata_nxt;
  logic                r_rsp_err, w_rsp_err_nxt;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]    r_wait_cnt, w_wait_cnt_nxt;
`else
  logic                w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

  // Next-state and next-output decode; every register holds unless changed.
  always_comb begin
    w_state_nxt     = r_state;
    w_psel_nxt      = r_psel;
    w_penable_nxt   = r_penable;
    w_pwrite_nxt    = r_pwrite;
    w_paddr_nxt     = r_paddr;
    w_pwdata_nxt    = r_pwdata;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_rsp_err_nxt   = r_rsp_err;
`ifdef APB_MASTER_TIMEOUT_EN
    w_wait_cnt_nxt  = r_wait_cnt;
`endif
    case (r_state)
      S_IDLE: begin
        if (cmd_valid_i) begin
          w_state_nxt   = S_SETUP;
          w_psel_nxt    = 1'b1;
          w_penable_nxt = 1'b0;
          w_pwrite_nxt  = cmd_write_i;
          w_paddr_nxt   = cmd_addr_i;
          w_pwdata_nxt  = cmd_write_i ? cmd_wdata_i : '0;
        end
      end
      S_SETUP: begin
        w_state_nxt   = S_ACCESS;
        w_penable_nxt = 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
        w_wait_cnt_nxt = '0;
`endif
      end
      S_ACCESS: begin
        if (pready_i) begin
          w_state_nxt     = S_IDLE;
          w_psel_nxt      = 1'b0;
          w_penable_nxt   = 1'b0;
          w_pwrite_nxt    = 1'b0;
          w_paddr_nxt     = '0;
          w_pwdata_nxt    = '0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_rdata_nxt = r_pwrite ? '0 : prdata_i;
          w_rsp_err_nxt   = 1'b0;
        end
`ifdef APB_MASTER_TIMEOUT_EN
        // Counter holds the number of earlier low-pready cycles, so the
        // limit is hit on the cycle that would be the TIMEOUT_CYCLES-th.
        else if (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          w_state_nxt     = S_IDLE;
          w_psel_nxt      = 1'b0;
          w_penable_nxt   = 1'b0;
          w_pwrite_nxt    = 1'b0;
          w_paddr_nxt     = '0;
          w_pwdata_nxt    = '0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_rdata_nxt = '0;
          w_rsp_err_nxt   = 1'b1;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + 1'b1;
        end
`endif
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and registered outputs; async active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_psel      <= w_psel_nxt;
      r_penable   <= w_penable_nxt;
      r_pwrite    <= w_pwrite_nxt;
      r_paddr     <= w_paddr_nxt;
      r_pwdata    <= w_pwdata_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
    end
  end

`ifdef APB_MASTER_TIMEOUT_EN
  // Wait-state counter for the ACCESS timeout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_wait_cnt <= '0;
    else        r_wait_cnt <= w_wait_cnt_nxt;
  end
  assign rsp_err_o = r_rsp_err;
`else
  logic w_unused_err;
  assign w_unused_err = r_rsp_err | w_rsp_err_nxt;
  assign rsp_err_o    = 1'b0;
`endif

  assign cmd_ready_o = (r_state == S_IDLE);
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_rdata_o = r_rsp_rdata;
  assign psel_o      = r_psel;
  assign penable_o   = r_penable;
  assign pwrite_o    = r_pwrite;
  assign paddr_o     = r_paddr;
  assign pwdata_o    = r_pwdata;

endmodule

// File: tb/tb_apb_master.sv
// Randomized self-checking bench for apb_master. Each transfer is modelled
// as a phase sequence (1 SETUP cycle, waits+1 ACCESS cycles or a timeout,
// then one response cycle) derived from the command fields.
module tb_apb_master;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int TO = 16;
`ifdef APB_MASTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic [AW-1:0] cmd_addr_i;
  logic          cmd_write_i;
  logic [DW-1:0] cmd_wdata_i;
  logic          rsp_valid_o;
  logic [DW-1:0] rsp_rdata_o;
  logic          rsp_err_o;
  logic          psel_o, penable_o, pwrite_o;
  logic [AW-1:0] paddr_o;
  logic [DW-1:0] pwdata_o;
  logic [DW-1:0] prdata_i;
  logic          pready_i;

  int n_checks = 0;
  int n_pass   = 0;
  logic [DW-1:0] exp_rdata;   // model of the held response data

  apb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_addr_i(cmd_addr_i), .cmd_write_i(cmd_write_i), .cmd_wdata_i(cmd_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
    .paddr_o(paddr_o), .pwdata_o(pwdata_o),
    .prdata_i(prdata_i), .pready_i(pready_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic check_bus_idle(input string tag);
    check({tag, "_psel"},    64'(psel_o),    64'd0);
    check({tag, "_penable"}, 64'(penable_o), 64'd0);
    check({tag, "_pwrite"},  64'(pwrite_o),  64'd0);
    check({tag, "_paddr"},   64'(paddr_o),   64'd0);
    check({tag, "_pwdata"},  64'(pwdata_o),  64'd0);
  endtask

  task automatic scramble_cmd(input logic keep_valid_low);
    cmd_valid_i = keep_valid_low ? 1'b0 : 1'($urandom);
    cmd_addr_i  = AW'($urandom);
    cmd_write_i = 1'($urandom);
    cmd_wdata_i = $urandom;
  endtask

  // Runs one transfer starting at a negedge with the master idle; returns at
  // the negedge of the response cycle with cmd_valid_i low.
  task automatic xfer(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] wd,
                      input int waits, input logic [DW-1:0] rd);
    logic [DW-1:0] exp_pw;
    bit timed_out;
    bit done;
    exp_pw = w ? wd : '0;
    check("ready_idle", 64'(cmd_ready_o), 64'd1);
    cmd_valid_i = 1'b1; cmd_addr_i = a; cmd_write_i = w; cmd_wdata_i = wd;
    pready_i = 1'($urandom); prdata_i = $urandom;
    @(negedge clk);
    scramble_cmd(1'b0);
    check("setup_psel",    64'(psel_o),      64'd1);
    check("setup_penable", 64'(penable_o),   64'd0);
    check("setup_pwrite",  64'(pwrite_o),    64'(w));
    check("setup_paddr",   64'(paddr_o),     64'(a));
    check("setup_pwdata",  64'(pwdata_o),    64'(exp_pw));
    check("setup_ready",   64'(cmd_ready_o), 64'd0);
    check("setup_rspv",    64'(rsp_valid_o), 64'd0);
    pready_i = 1'($urandom);
    @(negedge clk);
    timed_out = 1'b0;
    done = 1'b0;
    for (int i = 0; i <= waits && !done; i++) begin
      check("acc_psel",    64'(psel_o),      64'd1);
      check("acc_penable", 64'(penable_o),   64'd1);
      check("acc_pwrite",  64'(pwrite_o),    64'(w));
      check("acc_paddr",   64'(paddr_o),     64'(a));
      check("acc_pwdata",  64'(pwdata_o),    64'(exp_pw));
      check("acc_rspv",    64'(rsp_valid_o), 64'd0);
      pready_i = (i >= waits);
      prdata_i = pready_i ? rd : $urandom;
      scramble_cmd(1'b0);
      @(negedge clk);
      if (pready_i) done = 1'b1;
      else if (TO_EN && (i + 1 == TO)) begin done = 1'b1; timed_out = 1'b1; end
    end
    exp_rdata = (timed_out || w) ? '0 : rd;
    check_bus_idle("rsp");
    check("rsp_valid", 64'(rsp_valid_o), 64'd1);
    check("rsp_ready", 64'(cmd_ready_o), 64'd1);
    check("rsp_rdata", 64'(rsp_rdata_o), 64'(exp_rdata));
    check("rsp_err",   64'(rsp_err_o),   64'(timed_out));
    scramble_cmd(1'b1);
    pready_i = 1'($urandom);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    check("idle_rspv",  64'(rsp_valid_o), 64'd0);
    check("idle_rdata", 64'(rsp_rdata_o), 64'(exp_rdata));
    check("idle_ready", 64'(cmd_ready_o), 64'd1);
    check_bus_idle("idle");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] a;
    logic [DW-1:0] wd, rd;
    logic w;
    int waits;
    reset = 1'b0; cmd_valid_i = 1'b0; cmd_addr_i = '0; cmd_write_i = 1'b0;
    cmd_wdata_i = '0; prdata_i = '0; pready_i = 1'b0; exp_rdata = '0;
    repeat (2) @(negedge clk);
    check_bus_idle("rst");
    check("rst_ready", 64'(cmd_ready_o), 64'd1);
    check("rst_rspv",  64'(rsp_valid_o), 64'd0);
    check("rst_rdata", 64'(rsp_rdata_o), 64'd0);
    check("rst_err",   64'(rsp_err_o),   64'd0);
    reset = 1'b1;

    // Zero-wait write, then a read with three wait states.
    xfer(10'h00F, 1'b1, 32'hDEADBEE0, 0, 32'h0);
    idle_cycle();
    xfer(10'h00F, 1'b0, 32'h0, 3, 32'hDEADBEE1);
    idle_cycle();

    // Back-to-back: next command presented during the response cycle.
    xfer(10'h123, 1'b1, 32'h0BADF00D, 1, 32'h0);
    xfer(10'h321, 1'b0, 32'h0, 0, 32'hCAFEF00D);
    idle_cycle();

    // Reset during ACCESS: outputs clear asynchronously, no response.
    cmd_valid_i = 1'b1; cmd_addr_i = 10'h2AA; cmd_write_i = 1'b1; cmd_wdata_i = 32'h12345678;
    pready_i = 1'b0;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    @(negedge clk);
    check("pre_rst_penable", 64'(penable_o), 64'd1);
    #2 reset = 1'b0;
    #1;
    exp_rdata = '0;
    check_bus_idle("arst");
    check("arst_ready", 64'(cmd_ready_o), 64'd1);
    check("arst_rspv",  64'(rsp_valid_o), 64'd0);
    @(negedge clk);
    check("arst_hold_rspv", 64'(rsp_valid_o), 64'd0);
    reset = 1'b1;
    xfer(10'h055, 1'b0, 32'h0, 2, 32'hA5A55A5A);
    idle_cycle();

    // Wait-state limit behaviour.
    xfer(10'h3FF, 1'b0, 32'h0, 30, 32'h13572468);
    idle_cycle();
    xfer(10'h001, 1'b0, 32'h0, TO - 1, 32'h2468ACE0);
    idle_cycle();
    xfer(10'h002, 1'b1, 32'hFFFFFFFF, TO, 32'h0);
    idle_cycle();

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      a  = AW'($urandom);
      w  = 1'($urandom);
      wd = $urandom;
      rd = $urandom;
      waits = ($urandom_range(0, 9) == 0) ? $urandom_range(10, 20) : $urandom_range(0, 4);
      xfer(a, w, wd, waits, rd);
      if ($urandom_range(0, 1) == 0) idle_cycle();
    end
    idle_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
